// File: rtl/bram_sdp_if.sv
// rtl/bram_sdp_if.sv - write/read port bundle for the simple dual-port BRAM
// Master drives the access side; slave is the memory.
interface bram_sdp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int NB     = 2
);
  logic              ena;
  logic [NB-1:0]     wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dia;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dob;
  logic              dob_valid;
  logic              init_done;

  modport master (
    output ena, wea, addra, dia, enb, addrb,
    input  dob, dob_valid, init_done
  );

  modport slave (
    input  ena, wea, addra, dia, enb, addrb,
    output dob, dob_valid, init_done
  );
endinterface

// File: rtl/bram_sdp_param.sv
// rtl/bram_sdp_param.sv - byte-lane simple dual-port RAM with clear-after-reset
// Port A writes, port B reads; optional output register and collision forwarding.
module bram_sdp_param #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 10,
  parameter int BYTE_W         = 8,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  bram_sdp_if.slave  bus
);
  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_init_done;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_valid;

  logic              w_clear;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_rd_word;

  // init_done doubles as the "accesses accepted" qualifier
  assign w_clear = (r_state == S_CLEAR) && rst_n;
  assign w_wr    = r_init_done && bus.ena && (|bus.wea);
  assign w_rd    = r_init_done && bus.enb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      r_clr_addr  <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (&r_clr_addr) begin
            r_state     <= S_READY;
            r_init_done <= 1'b1;
          end
        end
        S_READY: r_init_done <= 1'b1;
        default: r_state <= S_READY;
      endcase
    end
  end

  // Array is never reset; zeroing only happens through the CLEAR sweep
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_mem[r_clr_addr] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wea[i]) r_mem[bus.addra][i*BYTE_W +: BYTE_W] <= bus.dia[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    w_rd_word = r_mem[bus.addrb];
    if ((RDW_MODE != 0) && w_wr && (bus.addra == bus.addrb)) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wea[i]) w_rd_word[i*BYTE_W +: BYTE_W] = bus.dia[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Data registers only load on a valid beat so dob holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_rd;
      if (w_rd) r_s1_data <= w_rd_word;
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_data <= r_s1_data;
    end
  end

  assign bus.dob       = (OUT_REG != 0) ? r_s2_data  : r_s1_data;
  assign bus.dob_valid = (OUT_REG != 0) ? r_s2_valid : r_s1_valid;
  assign bus.init_done = r_init_done;
endmodule

// File: doc/bram_sdp_param.md
BRAM_SDP_PARAM -- requirements
Module: bram_sdp_param

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of BYTE_W.
REQ-002 Parameter ADDR_W, default 10, address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter BYTE_W, default 8, bits per write-enable lane; NB = DATA_W/BYTE_W lanes.
REQ-004 Parameter OUT_REG, default 0, 1 adds an output pipeline register.
REQ-005 Parameter RDW_MODE, default 0; 0 = read-old, 1 = write-first (forward new data) on a same-address collision.
REQ-006 Parameter CLEAR_ON_RESET, default 1; 1 zero-fills memory after reset.
REQ-007 clk  in  1  single clock; all logic on posedge clk.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 ena  in  1  port A (write) enable.
REQ-010 wea  in  NB  per-lane write enable; wea[i] covers dia[i*BYTE_W +: BYTE_W].
REQ-011 addra  in  ADDR_W  write address.
REQ-012 dia  in  DATA_W  write data.
REQ-013 enb  in  1  port B (read) enable.
REQ-014 addrb  in  ADDR_W  read address.
REQ-015 dob  out  DATA_W  read data.
REQ-016 dob_valid  out  1  dob holds data for an accepted read this cycle.
REQ-017 init_done  out  1  memory ready; accesses accepted only while high.

Function
REQ-018 Controller SHALL have states CLEAR and READY; CLEAR_ON_RESET=1 enters CLEAR on reset release, CLEAR_ON_RESET=0 enters READY.
REQ-019 In CLEAR, an ADDR_W-bit counter SHALL write all-zero to addresses 0,1,...,2**ADDR_W-1, one per cycle, then go to READY on the cycle after the last address is written.
REQ-020 init_done SHALL be 0 in CLEAR and 1 in READY; ena, enb, wea SHALL be ignored while init_done=0.
REQ-021 In READY, a write SHALL occur when ena=1 and wea!=0, updating only lanes with wea[i]=1; other lanes unchanged.
REQ-022 ena=1 with wea=0 SHALL not modify memory.
REQ-023 A read accepted (enb=1, READY) at cycle N SHALL present mem[addrb] on dob with dob_valid=1 at cycle N+1 when OUT_REG=0, N+2 when OUT_REG=1.
REQ-024 dob_valid SHALL be a pulse per accepted read, pipelined with the data; back-to-back reads SHALL give back-to-back valid cycles, no bubbles.
REQ-025 dob SHALL hold its last value when no new read data arrives.
REQ-026 Collision (write and read same address, same cycle): RDW_MODE=0 SHALL return pre-write word; RDW_MODE=1 SHALL return written lanes from dia merged with unwritten lanes from the old word.
REQ-027 Different-address simultaneous read and write SHALL both complete with no interaction.
REQ-028 Write address wraps naturally at 2**ADDR_W; no out-of-range access exists.

Reset
REQ-029 rst_n=0 SHALL immediately force dob=0, dob_valid=0, init_done=0, clear counter=0, pipeline valid bits=0.
REQ-030 Memory contents SHALL NOT be reset asynchronously; zeroing happens only through CLEAR.
REQ-031 rst_n asserted mid-CLEAR or mid-read SHALL abort; in-flight reads SHALL not produce dob_valid; CLEAR restarts at address 0 on release.

Verification (DATA_W=16, ADDR_W=4, BYTE_W=8)
REQ-032 CLEAR_ON_RESET=1: release rst_n -> init_done rises exactly 16 cycles later; read of addresses 0..15 -> all 0x0000.
REQ-033 OUT_REG=0: write 0xBEEF to 5, next cycle read 5 -> dob=0xBEEF, dob_valid=1 one cycle after read; OUT_REG=1 -> two cycles after.
REQ-034 Byte lanes: mem[3]=0x1234, write 0xABCD with wea=2'b10 -> read 3 returns 0xAB34.
REQ-035 Collision at addr 7 holding 0x1111, write 0x2222 wea=2'b11 with read 7 same cycle -> RDW_MODE=0 returns 0x1111, RDW_MODE=1 returns 0x2222.
REQ-036 Assert rst_n=0 at clear address 8, release -> init_done stays 0 for 16 full cycles, no dob_valid; ena/enb pulsed during CLEAR -> memory unchanged, no dob_valid.
REQ-037 Reads of 0,1,2 on three consecutive cycles -> three consecutive dob_valid cycles with matching data in order.
